lockable_rr_arbiter: RTL
========================

# lockable_rr_arbiter

Parametrised N-channel arbiter that succeeds the fixed three-way cache-metadata arbiter in the data-cache pipeline. It adds selectable round-robin or fixed priority, multi-beat locking and a registered output stage. Requesters such as writeback, probe and refill units present {idx, way_en} requests. The single winner per accepted beat is buffered toward the metadata array. Full throughput: one beat per cycle when downstream is ready.

## Interface
- N, 3: number of request channels, 2..16
- IDX_W, 7: width of idx field
- WAY_W, 1: width of way_en field
- RR, 1: 1 = round-robin priority, 0 = fixed priority (channel 0 highest)
- CW, max(1, clog2(N)): width of io_chosen (derived, not overridable)

- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- io_in_valid  in  N  per-channel request valid
- io_in_ready  out  N  per-channel accept; at most one bit set
- io_in_bits_idx  in  N*IDX_W  channel i in bits [i*IDX_W +: IDX_W]
- io_in_bits_way_en  in  N*WAY_W  channel i in bits [i*WAY_W +: WAY_W]
- io_in_bits_last  in  N  1 = final beat of request; 0 = hold lock
- io_out_ready  in  1  downstream accept
- io_out_valid  out  1  output register holds a beat
- io_out_bits_idx  out  IDX_W  buffered idx
- io_out_bits_way_en  out  WAY_W  buffered way_en
- io_out_bits_last  out  1  buffered last flag
- io_chosen  out  CW  channel index of buffered beat

## Operation
- Output register slot. `can_take` = !io_out_valid | io_out_ready. Input transfer on channel i = io_in_valid[i] & io_in_ready[i]. Output transfer = io_out_valid & io_out_ready.
- Grant when unlocked:
  - Fixed mode: lowest-indexed valid channel wins.
  - RR mode: first valid channel searching ptr, ptr+1, … wrapping mod N.
- io_in_ready[w] = can_take for winner w only. All other ready bits are 0. With no valid input, all ready bits are 0.
- On input transfer: load the slot with the winner's idx/way_en/last and io_chosen = w. Set io_out_valid.
- If can_take and no input transfer: io_out_valid clears when the output transfers; the slot is otherwise unchanged.
- Lock:
  - An input transfer with last=0 sets lock and records channel L = w.
  - While locked, only channel L is eligible, even if L's valid is low and others are valid.
  - An input transfer from L with last=1 clears lock.
- Pointer: on an input transfer with last=1, ptr ← (w+1) mod N in RR mode. In fixed mode ptr stays 0. Beats with last=0 do not move ptr.
- Reset values: io_out_valid 0, io_out_bits_* 0, io_chosen 0, ptr 0, lock 0, L 0. io_in_ready follows combinationally; all ready bits are 1-free until valids arrive.
- Reset mid-request drops the lock and any buffered beat. No partial output is emitted afterwards.

## Timing
- Input accept to io_out_valid: 1 cycle. Ready depends combinationally on io_in_valid, io_out_ready and state.
- Back-to-back: with io_out_ready held high, one beat transfers per cycle, and winners rotate every cycle in RR mode when all last=1.
- Simultaneous input and output transfer in the same cycle: the slot is replaced with no bubble.
- Stall: with io_out_ready=0 and the slot full, every io_in_ready is 0 and the slot contents are held stable.
- Valid may drop without a transfer, except on a locked channel, where the lock persists indefinitely.
- ptr wrap: with N=3, after a grant to channel 2, ptr=0.

## Structure
- Shared package arb_pkg holds:
  - CW computation function (clog2 with minimum 1)
  - RR/FIXED mode constants
- Sub-module rr_pick: combinational find-first-set starting at a rotating base. Inputs req[N] and base[CW]; outputs gnt_idx[CW] and any. It is instantiated once. The fixed mode ties base to 0.
- The top level holds the output register, ptr, lock and L, plus the ready/select muxing.

## Test plan
- N=3, RR=0: all three channels valid with last=1 and io_out_ready=1. Grants are 0,0,0 each cycle. io_chosen=0 one cycle after each accept. Data for idx=0x12 from channel 0 appears unchanged.
- N=3, RR=1: all valid, last=1, ready=1. io_chosen sequence 0,1,2,0,1,… starting in the cycle after reset release.
- Lock: channel 1 sends beats with last=0,0,1 while channels 0 and 2 are valid. Channel 1 gets ready for 3 consecutive accepts and channels 0/2 ready=0. Then the next grant is 2 in RR mode.
- Backpressure: io_out_ready=0 for 4 cycles with the slot full. All io_in_ready=0 and io_out_bits are stable. When ready rises, there is 1 accept per cycle with no lost beat.
- Reset while locked on channel 2 with a buffered beat: the next cycle shows io_out_valid=0 and lock cleared. Channel 0 is then granted first.
- N=16, IDX_W=12, RR=1: only channels 5 and 15 valid. Grants alternate 5,15,5; io_chosen is 4 bits wide.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants and helpers for the lockable round-robin arbiter.
// Holds the priority-mode encodings and the io_chosen width rule.
package arb_pkg;

  localparam bit MODE_RR    = 1'b1;
  localparam bit MODE_FIXED = 1'b0;

  function automatic int cw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lockable_rr_arbiter_rr_pick.sv
// Combinational find-first-set over req, searching base, base+1, ... mod N.
// any is high when at least one request is set.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int CW = cw_of(N)
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] base,
  output logic [CW-1:0] gnt_idx,
  output logic          any
);

  always_comb begin
    int            j;
    logic [CW-1:0] jj;
    j       = 0;
    jj      = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < N; k++) begin
      j  = (int'(base) + k) % N;
      jj = CW'(j);
      if (!any && req[jj]) begin
        any     = 1'b1;
        gnt_idx = jj;
      end
    end
  end

endmodule

// File: rtl/lockable_rr_arbiter.sv
// N-channel arbiter with round-robin or fixed priority, multi-beat locking
// and a single registered output slot that sustains one beat per cycle.
module lockable_rr_arbiter
  import arb_pkg::*;
#(
  parameter  int N     = 3,
  parameter  int IDX_W = 7,
  parameter  int WAY_W = 1,
  parameter  bit RR    = MODE_RR,
  localparam int CW    = cw_of(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         io_in_valid,
  output logic [N-1:0]         io_in_ready,
  input  logic [N*IDX_W-1:0]   io_in_bits_idx,
  input  logic [N*WAY_W-1:0]   io_in_bits_way_en,
  input  logic [N-1:0]         io_in_bits_last,
  input  logic                 io_out_ready,
  output logic                 io_out_valid,
  output logic [IDX_W-1:0]     io_out_bits_idx,
  output logic [WAY_W-1:0]     io_out_bits_way_en,
  output logic                 io_out_bits_last,
  output logic [CW-1:0]        io_chosen
);

  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic [WAY_W-1:0] out_way_q, out_way_d;
  logic             out_last_q, out_last_d;
  logic [CW-1:0]    chosen_q, chosen_d;
  logic [CW-1:0]    ptr_q, ptr_d;
  logic             lock_q, lock_d;
  logic [CW-1:0]    lock_ch_q, lock_ch_d;

  logic          can_take, win_vld, win_last, xfer, pick_any;
  logic [CW-1:0] pick_base, pick_idx, win_idx;

  assign can_take  = !out_valid_q | io_out_ready;
  assign pick_base = (RR == MODE_RR) ? ptr_q : '0;

  rr_pick #(
    .N  (N),
    .CW (CW)
  ) u_pick (
    .req     (io_in_valid),
    .base    (pick_base),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // A held lock pins the grant to its owner even while the owner is idle.
  assign win_idx     = lock_q ? lock_ch_q : pick_idx;
  assign win_vld     = lock_q ? io_in_valid[lock_ch_q] : pick_any;
  assign xfer        = win_vld & can_take;
  assign io_in_ready = xfer ? (N'(1) << win_idx) : '0;
  assign win_last    = io_in_bits_last[win_idx];

  always_comb begin
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_way_d   = out_way_q;
    out_last_d  = out_last_q;
    chosen_d    = chosen_q;
    ptr_d       = ptr_q;
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_idx_d   = io_in_bits_idx[int'(win_idx)*IDX_W +: IDX_W];
      out_way_d   = io_in_bits_way_en[int'(win_idx)*WAY_W +: WAY_W];
      out_last_d  = win_last;
      chosen_d    = win_idx;
      lock_d      = !win_last;
      if (!win_last) begin
        lock_ch_d = win_idx;
      end else if (RR == MODE_RR) begin
        ptr_d = (win_idx == CW'(N - 1)) ? '0 : win_idx + 1'b1;
      end
    end else if (io_out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output slot and arbitration state
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_way_q   <= '0;
      out_last_q  <= 1'b0;
      chosen_q    <= '0;
      ptr_q       <= '0;
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_way_q   <= out_way_d;
      out_last_q  <= out_last_d;
      chosen_q    <= chosen_d;
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
    end
  end

  assign io_out_valid       = out_valid_q;
  assign io_out_bits_idx    = out_idx_q;
  assign io_out_bits_way_en = out_way_q;
  assign io_out_bits_last   = out_last_q;
  assign io_chosen          = chosen_q;

endmodule
